// File: rtl/pingpong_ctrl_pkg.sv
// Shared definitions for the ping-pong bank-swap controller.
package pingpong_ctrl_pkg;

  // Write bank: filling, or holding a complete map that waits for a swap.
  typedef enum logic {WR_FILL = 1'b0, WR_FULL = 1'b1} wr_state_t;

  // Read bank: nothing left to read, or holding an unread/partly read map.
  typedef enum logic {RD_EMPTY = 1'b0, RD_VALID = 1'b1} rd_state_t;

  // Bits needed to index v entries (at least 1).
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int x = v - 1; x > 0; x = x >> 1) r++;
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo-DEPTH address counter with a synchronous clear and a wrap pulse.
module mod_counter
  import pingpong_ctrl_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_en,
  input  logic                  i_clr,
  output logic [ADDR_WIDTH-1:0] o_count,
  output logic                  o_wrap
);

  logic [ADDR_WIDTH-1:0] r_count;
  logic                  w_at_max;

  assign w_at_max = (r_count == ADDR_WIDTH'(DEPTH - 1));
  assign o_wrap   = i_en & w_at_max;
  assign o_count  = r_count;

  // Count enabled events, wrapping to 0 after DEPTH-1 so the index stays in range.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       r_count <= '0;
    else if (i_clr)  r_count <= '0;
    else if (i_en)   r_count <= w_at_max ? '0 : r_count + 1'b1;
  end

endmodule

// File: rtl/pingpong_ctrl.sv
// Ping-pong bank-swap controller: write strobes for the fill bank, paced reads
// from the drain bank, and an ifm_sel toggle once both sides are done.
module pingpong_ctrl
  import pingpong_ctrl_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  prod_valid,
  output logic                  prod_ready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic                  ifm_sel,
  output logic                  rd_bank_valid,
  input  logic                  cons_req,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_last,
  output logic                  rd_data_valid,
  output logic                  swap_pulse
);

  if (DEPTH < 2) begin : g_bad_depth
    $error("pingpong_ctrl: DEPTH must be >= 2");
  end
  if (clog2(DEPTH) > ADDR_WIDTH) begin : g_bad_aw
    $error("pingpong_ctrl: ADDR_WIDTH too narrow for DEPTH");
  end

  wr_state_t r_wr_state;
  rd_state_t r_rd_state;
  logic      r_ifm_sel;
  logic      r_rd_data_valid;
  logic      r_swap_pulse;

  logic      w_wr_full;
  logic      w_rd_valid;
  logic      w_wr_wrap;
  logic      w_rd_wrap;
  logic      w_swap;

  assign w_wr_full  = (r_wr_state == WR_FULL);
  assign w_rd_valid = (r_rd_state == RD_VALID);

  assign prod_ready = !w_wr_full;
  assign wr_en      = prod_valid & prod_ready;
  assign rd_en      = cons_req & w_rd_valid;
  assign rd_last    = w_rd_wrap;

  // Swap once the fill bank is complete and the drain bank is empty or finishing
  // its last read this cycle (that read still captures under the old ifm_sel).
  assign w_swap = w_wr_full & (!w_rd_valid | w_rd_wrap);

  assign ifm_sel       = r_ifm_sel;
  assign rd_bank_valid = w_rd_valid;
  assign rd_data_valid = r_rd_data_valid;
  assign swap_pulse    = r_swap_pulse;

  mod_counter #(.DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH)) u_wr_cnt (
    .clk     (clk),
    .reset   (reset),
    .i_en    (wr_en),
    .i_clr   (1'b0),
    .o_count (wr_addr),
    .o_wrap  (w_wr_wrap)
  );

  mod_counter #(.DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH)) u_rd_cnt (
    .clk     (clk),
    .reset   (reset),
    .i_en    (rd_en),
    .i_clr   (w_swap),
    .o_count (rd_addr),
    .o_wrap  (w_rd_wrap)
  );

  // Bank state machines plus registered bank select, swap pulse and read-data valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_state      <= WR_FILL;
      r_rd_state      <= RD_EMPTY;
      r_ifm_sel       <= 1'b0;
      r_rd_data_valid <= 1'b0;
      r_swap_pulse    <= 1'b0;
    end else begin
      r_rd_data_valid <= rd_en;
      r_swap_pulse    <= w_swap;
      if (w_swap) r_ifm_sel <= ~r_ifm_sel;

      case (r_wr_state)
        WR_FILL: if (w_wr_wrap) r_wr_state <= WR_FULL;
        WR_FULL: if (w_swap)    r_wr_state <= WR_FILL;
        default:                r_wr_state <= WR_FILL;
      endcase

      case (r_rd_state)
        RD_EMPTY: if (w_swap)  r_rd_state <= RD_VALID;
        RD_VALID: if (!w_swap && w_rd_wrap) r_rd_state <= RD_EMPTY;
        default:               r_rd_state <= RD_EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_pingpong_ctrl.sv
// Bench for pingpong_ctrl at DEPTH=4: scripted per-cycle vectors, an async
// reset check, and a streaming run with a write->read word scoreboard.
module tb_pingpong_ctrl;

  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          prod_valid, cons_req;
  logic          prod_ready, wr_en, ifm_sel, rd_bank_valid;
  logic          rd_en, rd_last, rd_data_valid, swap_pulse;
  logic [AW-1:0] wr_addr, rd_addr;

  pingpong_ctrl #(.DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clk           (clk),
    .reset         (reset),
    .prod_valid    (prod_valid),
    .prod_ready    (prod_ready),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .ifm_sel       (ifm_sel),
    .rd_bank_valid (rd_bank_valid),
    .cons_req      (cons_req),
    .rd_en         (rd_en),
    .rd_addr       (rd_addr),
    .rd_last       (rd_last),
    .rd_data_valid (rd_data_valid),
    .swap_pulse    (swap_pulse)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          prod_ready;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic          ifm_sel;
    logic          rd_bank_valid;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic          rd_last;
    logic          rd_data_valid;
    logic          swap_pulse;
  } out_t;

  typedef struct {
    logic pv;
    logic cr;
    out_t exp;
  } vec_t;

  out_t act;
  assign act = {prod_ready, wr_en, wr_addr, ifm_sel, rd_bank_valid, rd_en,
                rd_addr, rd_last, rd_data_valid, swap_pulse};

  vec_t tbl[$];
  int   sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic add(input int pv, cr, pr, we, wa, sel, rbv, re, ra, rl, rdv, sp);
    vec_t v;
    v.pv  = pv[0];
    v.cr  = cr[0];
    v.exp = {pr[0], we[0], wa[AW-1:0], sel[0], rbv[0], re[0], ra[AW-1:0],
             rl[0], rdv[0], sp[0]};
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input int a, input int e);
    total++;
    if (a != e) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, a, e);
    end
  endtask

  task automatic chk_out(input string nm, input out_t e);
    total++;
    if (act !== e) begin
      bad++;
      $display("FAIL %s: got %b expected %b (pr we wa sel rbv re ra rl rdv sp)",
               nm, act, e);
    end
  endtask

  localparam out_t RST_OUT = {1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0};

  initial begin
    int last_ra;
    int exp_w, nsp, last_sp, nwr, nrd, ngap;

    //   pv cr | pr we wa sel rbv re ra rl rdv sp
    // first fill, then cons_req while nothing readable, then swap
    add(1,0, 1,1,0, 0,0, 0,0,0, 0,0);
    add(1,0, 1,1,1, 0,0, 0,0,0, 0,0);
    add(1,0, 1,1,2, 0,0, 0,0,0, 0,0);
    add(1,0, 1,1,3, 0,0, 0,0,0, 0,0);
    add(1,1, 0,0,0, 0,0, 0,0,0, 0,0);
    // refill with consumer idle: producer blocked, no toggle
    add(1,0, 1,1,0, 1,1, 0,0,0, 0,1);
    add(1,0, 1,1,1, 1,1, 0,0,0, 0,0);
    add(1,0, 1,1,2, 1,1, 0,0,0, 0,0);
    add(1,0, 1,1,3, 1,1, 0,0,0, 0,0);
    add(1,0, 0,0,0, 1,1, 0,0,0, 0,0);
    add(1,0, 0,0,0, 1,1, 0,0,0, 0,0);
    // alternate-cycle reads; the 4th is rd_last and swaps on the same edge
    add(1,1, 0,0,0, 1,1, 1,0,0, 0,0);
    add(1,0, 0,0,0, 1,1, 0,1,0, 1,0);
    add(1,1, 0,0,0, 1,1, 1,1,0, 0,0);
    add(1,0, 0,0,0, 1,1, 0,2,0, 1,0);
    add(1,1, 0,0,0, 1,1, 1,2,0, 0,0);
    add(1,0, 0,0,0, 1,1, 0,3,0, 1,0);
    add(1,1, 0,0,0, 1,1, 1,3,1, 0,0);
    add(0,0, 1,0,0, 0,1, 0,0,0, 1,1);
    // last write and last read together: full first, swap one cycle later
    add(1,1, 1,1,0, 0,1, 1,0,0, 0,0);
    add(1,1, 1,1,1, 0,1, 1,1,0, 1,0);
    add(1,1, 1,1,2, 0,1, 1,2,0, 1,0);
    add(1,1, 1,1,3, 0,1, 1,3,1, 1,0);
    add(1,1, 0,0,0, 0,0, 0,0,0, 1,0);
    add(1,1, 1,1,0, 1,1, 1,0,0, 0,1);
    add(0,0, 1,0,1, 1,1, 0,1,0, 1,0);

    prod_valid = 1'b0;
    cons_req   = 1'b0;
    reset      = 1'b1;
    @(negedge clk);
    chk_out("reset_state", RST_OUT);

    // Async reset mid-fill: two writes, then reset between edges.
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1 prod_valid = 1'b1;
    @(posedge clk);
    @(posedge clk); #1 prod_valid = 1'b0;
    chk("midfill_wr_addr", int'(wr_addr), 2);
    #2 reset = 1'b1;
    #1 chk_out("async_reset_midfill", RST_OUT);
    @(posedge clk); #1 reset = 1'b0;

    // Table phase with read scoreboard.
    last_ra = 0;
    foreach (tbl[i]) begin
      @(posedge clk); #1;
      prod_valid = tbl[i].pv;
      cons_req   = tbl[i].cr;
      if (tbl[i].exp.rd_en) sb.push_back(int'(tbl[i].exp.rd_addr));
      @(negedge clk);
      chk_out($sformatf("row%0d", i), tbl[i].exp);
      if (rd_data_valid) begin
        if (sb.size() == 0) chk("sb_unexpected_rdv", 1, 0);
        else                chk("sb_rd_data", last_ra, sb.pop_front());
      end
      if (rd_en) last_ra = int'(rd_addr);
    end
    chk("sb_left_over", sb.size(), 0);
    sb.delete();

    // Continuous streaming from reset, both sides always active.
    #1 reset = 1'b1;
    prod_valid = 1'b0;
    cons_req   = 1'b0;
    @(posedge clk); #1 reset = 1'b0;
    exp_w = 0; nsp = 0; last_sp = -1; nwr = 0; nrd = 0; ngap = 0;
    for (int cyc = 0; cyc < 26; cyc++) begin
      @(posedge clk); #1;
      prod_valid = 1'b1;
      cons_req   = 1'b1;
      @(negedge clk);
      if (wr_en) begin
        chk("cont_wr_addr", int'(wr_addr), exp_w);
        sb.push_back(exp_w);
        exp_w = (exp_w + 1) % DEPTH;
        nwr++;
      end
      if (rd_en) begin
        if (sb.size() == 0) chk("cont_rd_no_word", 1, 0);
        else                chk("cont_rd_addr", int'(rd_addr), sb.pop_front());
        nrd++;
      end
      if (swap_pulse) begin
        if (last_sp < 0) chk("first_swap_cycle", cyc, 5);
        else             chk("swap_interval", cyc - last_sp, DEPTH + 1);
        last_sp = cyc;
        nsp++;
      end
      if (cyc > 5 && !rd_bank_valid) ngap++;
    end
    chk("cont_swap_count", nsp, 5);
    chk("cont_writes", nwr, 21);
    chk("cont_reads", nrd, 17);
    chk("cont_rbv_gap_cycles", ngap, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
